// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for serial_adder.
// The master drives the request side; the slave (the adder) drives status and result.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor that consumes DIGIT bits per clock, LSB first.
// Operands are latched on start; the result is published with a one-cycle done pulse.
module serial_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = $clog2(N + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] a_sh_q,   a_sh_d;
  logic [WIDTH-1:0] b_sh_q,   b_sh_d;
  logic [WIDTH-1:0] res_q,    res_d;
  logic             carry_q,  carry_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic             a_msb_q,  a_msb_d;
  logic             b_msb_q,  b_msb_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic [WIDTH-1:0] sum_q,    sum_d;
  logic             cout_q,   cout_d;
  logic             ovf_q,    ovf_d;

  logic [DIGIT:0]   digit_sum;
  logic [WIDTH-1:0] res_shift;
  logic [WIDTH-1:0] b_eff;

  // One digit of the ripple; new digits enter the result register from the top.
  always_comb begin
    digit_sum = (DIGIT+1)'(a_sh_q[DIGIT-1:0]) + (DIGIT+1)'(b_sh_q[DIGIT-1:0])
              + (DIGIT+1)'(carry_q);
    res_shift = (res_q >> DIGIT) | (WIDTH'(digit_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
    b_eff     = bus.sub ? ~bus.b : bus.b;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = b_eff;
          carry_d = bus.sub ? 1'b1 : bus.cin;
          cnt_d   = '0;
          a_msb_d = bus.a[WIDTH-1];
          b_msb_d = b_eff[WIDTH-1];
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_sh_d  = a_sh_q >> DIGIT;
        b_sh_d  = b_sh_q >> DIGIT;
        carry_d = digit_sum[DIGIT];
        cnt_d   = cnt_q + CW'(1);
        res_d   = res_shift;
        // Last digit: publish the fully assembled result while entering DONE.
        if (cnt_q == CW'(N - 1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          sum_d   = res_shift;
          cout_d  = digit_sum[DIGIT];
          ovf_d   = (a_msb_q == b_msb_q) && (res_shift[WIDTH-1] != a_msb_q);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at DIGIT = 1, 4 and 2 (WIDTH = 8).
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] start_v = 3'b000;
  logic       sub_v = 1'b0;
  logic       cin_v = 1'b0;
  logic [7:0] a_v = 8'h00;
  logic [7:0] b_v = 8'h00;

  int checks = 0;
  int errors = 0;

  serial_adder_if #(.WIDTH(8)) if0 ();
  serial_adder_if #(.WIDTH(8)) if1 ();
  serial_adder_if #(.WIDTH(8)) if2 ();

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  serial_adder #(.WIDTH(8), .DIGIT(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  serial_adder #(.WIDTH(8), .DIGIT(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  assign if0.start = start_v[0];
  assign if1.start = start_v[1];
  assign if2.start = start_v[2];
  assign if0.sub = sub_v;  assign if1.sub = sub_v;  assign if2.sub = sub_v;
  assign if0.cin = cin_v;  assign if1.cin = cin_v;  assign if2.cin = cin_v;
  assign if0.a   = a_v;    assign if1.a   = a_v;    assign if2.a   = a_v;
  assign if0.b   = b_v;    assign if1.b   = b_v;    assign if2.b   = b_v;

  logic [2:0] busy_o, done_o, cout_o, ovf_o;
  logic [7:0] sum_o [3];
  assign busy_o = {if2.busy, if1.busy, if0.busy};
  assign done_o = {if2.done, if1.done, if0.done};
  assign cout_o = {if2.cout, if1.cout, if0.cout};
  assign ovf_o  = {if2.ovf,  if1.ovf,  if0.ovf};
  assign sum_o[0] = if0.sum;
  assign sum_o[1] = if1.sum;
  assign sum_o[2] = if2.sum;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; launches one operation and returns at the negedge where done is seen.
  task automatic run_op(input int idx, input logic s, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input int n, input logic [7:0] es, input logic ec,
                        input logic eo, input string tag);
    int busy_cnt = 0;
    int done_cyc = 0;
    sub_v = s; a_v = a; b_v = b; cin_v = c;
    start_v[idx] = 1'b1;
    @(negedge clk);
    start_v[idx] = 1'b0;
    for (int cyc = 1; cyc <= n + 4; cyc++) begin
      if (busy_o[idx]) busy_cnt++;
      if (done_o[idx]) begin
        done_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(n));
    chk({tag, "_done_cycle"},  32'(done_cyc), 32'(n + 1));
    chk({tag, "_sum"},  32'(sum_o[idx]), 32'(es));
    chk({tag, "_cout"}, 32'(cout_o[idx]), 32'(ec));
    chk({tag, "_ovf"},  32'(ovf_o[idx]),  32'(eo));
  endtask

  initial begin
    int dones;
    int first_done;

    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_busy", 32'(busy_o[i]), 32'd0);
      chk("rst_done", 32'(done_o[i]), 32'd0);
      chk("rst_sum",  32'(sum_o[i]),  32'd0);
      chk("rst_cout", 32'(cout_o[i]), 32'd0);
      chk("rst_ovf",  32'(ovf_o[i]),  32'd0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(0, 1'b0, 8'h3C, 8'h0F, 1'b0, 8, 8'h4B, 1'b0, 1'b0, "add_d1");
    @(negedge clk);
    chk("add_d1_single_pulse", 32'(done_o[0]), 32'd0);

    run_op(1, 1'b0, 8'hFF, 8'h01, 1'b1, 2, 8'h01, 1'b1, 1'b0, "add_d4");
    @(negedge clk);
    run_op(2, 1'b1, 8'h05, 8'h07, 1'b1, 4, 8'hFE, 1'b0, 1'b0, "sub_d2");
    @(negedge clk);
    run_op(2, 1'b1, 8'h80, 8'h01, 1'b0, 4, 8'h7F, 1'b1, 1'b1, "sub_ovf_d2");
    @(negedge clk);
    run_op(0, 1'b0, 8'h7F, 8'h01, 1'b0, 8, 8'h80, 1'b0, 1'b1, "ovf_d1");
    @(negedge clk);

    // Start again with new operands during RUN; neither may disturb the running operation.
    sub_v = 1'b0; cin_v = 1'b0; a_v = 8'h12; b_v = 8'h34;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start_v[0] = 1'b1; a_v = 8'hFF; b_v = 8'hFF;
    @(negedge clk);
    start_v[0] = 1'b0;
    dones = 0;
    first_done = 0;
    for (int cyc = 4; cyc <= 16; cyc++) begin
      if (done_o[0]) begin
        dones++;
        if (first_done == 0) begin
          first_done = cyc;
          chk("ignore_sum", 32'(sum_o[0]), 32'h46);
        end
      end
      @(negedge clk);
    end
    chk("ignore_done_count", 32'(dones), 32'd1);
    chk("ignore_done_cycle", 32'(first_done), 32'd9);
    for (int i = 0; i < 5; i++) begin
      chk("hold_sum",  32'(sum_o[0]),  32'h46);
      chk("hold_busy", 32'(busy_o[0]), 32'd0);
      @(negedge clk);
    end

    // Back-to-back: the second start is presented in the cycle right after done.
    run_op(0, 1'b0, 8'h7F, 8'h01, 1'b0, 8, 8'h80, 1'b0, 1'b1, "b2b_first");
    @(negedge clk);
    chk("b2b_done_low", 32'(done_o[0]), 32'd0);
    run_op(0, 1'b0, 8'hC8, 8'h64, 1'b1, 8, 8'h2D, 1'b1, 1'b0, "b2b_second");
    @(negedge clk);

    // Asynchronous reset in the middle of RUN.
    a_v = 8'hAA; b_v = 8'h55; cin_v = 1'b1;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", 32'(busy_o[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy_o[0]), 32'd0);
    chk("async_rst_done", 32'(done_o[0]), 32'd0);
    chk("async_rst_sum",  32'(sum_o[0]),  32'd0);
    chk("async_rst_cout", 32'(cout_o[0]), 32'd0);
    chk("async_rst_ovf",  32'(ovf_o[0]),  32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle_busy", 32'(busy_o[0]), 32'd0);
    chk("post_rst_idle_done", 32'(done_o[0]), 32'd0);
    run_op(0, 1'b0, 8'h01, 8'h01, 1'b0, 8, 8'h02, 1'b0, 1'b0, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
